// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: FSM state encoding,
// row operation encoding and default bus geometry.
package memory_controller_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_ADDR_W = 2;

    // Plain 2-bit encoding keeps the state register readable in legacy tools.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/memory_controller_if.sv
// Host-side request/response handshake plus the row-side memory bus,
// bundled so the controller and its environment share one definition.
interface memory_controller_if
    import memory_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    // Host side
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    // Row side
    logic [ROWS-1:0]   S;
    logic              op;
    logic [DATA_W-1:0] data_input;
    logic [DATA_W-1:0] data_output;

    // Controller view
    modport slave (
        input  req, we, addr, wdata, data_output,
        output ready, done, err, rdata, S, op, data_input
    );

    // Host plus row-array view
    modport master (
        output req, we, addr, wdata, data_output,
        input  ready, done, err, rdata, S, op, data_input
    );

endinterface

// File: rtl/memory_controller_row_decoder.sv
// Turns a row index into a one-hot row select, gated by an enable, and
// flags indices that fall outside the populated rows.
module row_decoder #(
    parameter int ROWS   = 4,
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    output logic [ROWS-1:0]   o_sel,
    output logic              o_range_err
);

    // Out-of-range indices simply match no row, so o_sel stays all-zero.
    assign o_range_err = int'(i_addr) >= ROWS;

    // One-hot decode of the row index while enabled.
    always_comb begin
        // NOTE: default every output first so no path leaves o_sel unassigned (latch).
        o_sel = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i_en && (int'(i_addr) == i)) begin
                o_sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_controller.sv
// Four-phase row-memory sequencer: IDLE -> SETUP -> ACCESS -> DONE.
// A request is latched in IDLE, the row bus is set up for one cycle with
// no row selected, the addressed row is strobed for one cycle, and the
// completion is reported with a single-cycle done pulse.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    memory_controller_if.slave  bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_access;
    logic [ROWS-1:0]   w_sel;
    logic              w_range_err;

    assign w_access = (r_state == ST_ACCESS);

    row_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .i_addr      (r_addr),
        .i_en        (w_access),
        .o_sel       (w_sel),
        .o_range_err (w_range_err)
    );

    // FSM sequencing, request latching and read-data capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= OP_READ;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_addr  <= bus.addr;
                        r_we    <= bus.we;
                        r_wdata <= bus.wdata;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A read of a missing row returns zero instead of bus noise.
                    if (r_we == OP_READ) begin
                        r_rdata <= w_range_err ? '0 : bus.data_output;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // op and data_input come straight from the latched request, so they are
    // stable for the whole SETUP..DONE window while the row select pulses.
    assign bus.ready      = (r_state == ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = (r_state == ST_DONE) && w_range_err;
    assign bus.rdata      = r_rdata;
    assign bus.S          = w_sel;
    assign bus.op         = r_we;
    assign bus.data_input = r_wdata;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: a 4-row instance with a small row
// model driven from a vector table, plus a 3-row instance for the
// out-of-range path, and hand-written throughput and reset sequences.
module tb_memory_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_controller_if #(.DATA_W(8), .ROWS(4), .ADDR_W(2)) if4 ();
    memory_controller_if #(.DATA_W(8), .ROWS(3), .ADDR_W(2)) if3 ();

    memory_controller #(.DATA_W(8), .ROWS(4), .ADDR_W(2)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    memory_controller #(.DATA_W(8), .ROWS(3), .ADDR_W(2)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    // Row array for the 4-row instance: loads known contents on reset,
    // writes on a selected write cycle, reads 0xEE when nothing is selected.
    logic [7:0] mem4 [4];

    always @(posedge clk) begin
        if (rst) begin
            mem4[0] <= 8'h10;
            mem4[1] <= 8'h3C;
            mem4[2] <= 8'h20;
            mem4[3] <= 8'h30;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (if4.S[i] && if4.op) mem4[i] <= if4.data_input;
            end
        end
    end

    always_comb begin
        if4.data_output = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            if (if4.S[i]) if4.data_output = mem4[i];
        end
    end

    // The 3-row array answers 0x3C for any selected row, 0xEE otherwise.
    assign if3.data_output = (|if3.S) ? 8'h3C : 8'hEE;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [3:0] exp_s;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // One full transaction on the 4-row instance with per-cycle checks.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check("idle_ready", if4.ready, 1);
        if4.req   = 1'b1;
        if4.we    = v.we;
        if4.addr  = v.addr;
        if4.wdata = v.wdata;
        @(negedge clk);
        if4.req = 1'b0;
        check("setup_ready", if4.ready, 0);
        check("setup_S", if4.S, 0);
        check("setup_op", if4.op, v.we);
        check("setup_din", if4.data_input, v.wdata);
        check("setup_done", if4.done, 0);
        @(negedge clk);
        check("access_S", if4.S, v.exp_s);
        check("access_op", if4.op, v.we);
        check("access_din", if4.data_input, v.wdata);
        check("access_done", if4.done, 0);
        @(negedge clk);
        check("done_pulse", if4.done, 1);
        check("done_err", if4.err, v.exp_err);
        check("done_S", if4.S, 0);
        check("done_ready", if4.ready, 0);
        check("done_rdata", if4.rdata, v.exp_rdata);
        @(negedge clk);
        check("after_done", if4.done, 0);
        check("after_ready", if4.ready, 1);
    endtask

    // One transaction on the 3-row instance; S is checked in every cycle.
    task automatic run3(input logic [1:0] addr, input logic [2:0] exp_s,
                        input logic exp_err, input logic [7:0] exp_rdata);
        @(negedge clk);
        check("r3_ready", if3.ready, 1);
        if3.req  = 1'b1;
        if3.we   = 1'b0;
        if3.addr = addr;
        @(negedge clk);
        if3.req = 1'b0;
        check("r3_setup_S", if3.S, 0);
        check("r3_setup_done", if3.done, 0);
        @(negedge clk);
        check("r3_access_S", if3.S, exp_s);
        @(negedge clk);
        check("r3_done", if3.done, 1);
        check("r3_err", if3.err, exp_err);
        check("r3_done_S", if3.S, 0);
        check("r3_rdata", if3.rdata, exp_rdata);
        @(negedge clk);
        check("r3_after_done", if3.done, 0);
        check("r3_after_err", if3.err, 0);
    endtask

    initial begin
        //           we    addr   wdata  exp_s    err   rdata
        vecs[0] = '{1'b1, 2'd2, 8'hA5, 4'b0100, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 2'd1, 8'h00, 4'b0010, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 2'd2, 8'h00, 4'b0100, 1'b0, 8'hA5};
        vecs[3] = '{1'b1, 2'd3, 8'hFF, 4'b1000, 1'b0, 8'hA5};
        vecs[4] = '{1'b0, 2'd3, 8'h00, 4'b1000, 1'b0, 8'hFF};
        vecs[5] = '{1'b1, 2'd0, 8'h55, 4'b0001, 1'b0, 8'hFF};
        vecs[6] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, 8'h55};

        rst = 1'b1;
        if4.req = 1'b0; if4.we = 1'b0; if4.addr = '0; if4.wdata = '0;
        if3.req = 1'b0; if3.we = 1'b0; if3.addr = '0; if3.wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", if4.ready, 1);
        check("rst_done", if4.done, 0);
        check("rst_err", if4.err, 0);
        check("rst_rdata", if4.rdata, 0);
        check("rst_S", if4.S, 0);
        check("rst_op", if4.op, 0);
        check("rst_din", if4.data_input, 0);

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // req held high: one access every 4 cycles, requests while busy dropped
        @(negedge clk);
        if4.req  = 1'b1;
        if4.we   = 1'b0;
        if4.addr = 2'd1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("bb_ready", if4.ready, (c % 4) == 3);
            check("bb_done", if4.done, (c % 4) == 2);
            check("bb_S", if4.S, ((c % 4) == 1) ? 4'b0010 : 4'b0000);
            if ((c % 4) == 2) check("bb_rdata", if4.rdata, 8'h3C);
        end
        if4.req = 1'b0;

        // Reset during ACCESS aborts the access; reset beats a pending req
        @(negedge clk);
        check("ab_ready", if4.ready, 1);
        if4.req   = 1'b1;
        if4.we    = 1'b1;
        if4.addr  = 2'd2;
        if4.wdata = 8'h77;
        @(negedge clk);
        if4.req = 1'b0;
        @(negedge clk);
        check("ab_access_S", if4.S, 4'b0100);
        rst = 1'b1;
        if4.req = 1'b1;
        @(negedge clk);
        check("ab_idle_ready", if4.ready, 1);
        check("ab_no_done", if4.done, 0);
        check("ab_S", if4.S, 0);
        @(negedge clk);
        check("ab_rst_prio", if4.ready, 1);
        check("ab_no_done2", if4.done, 0);
        check("ab_rdata", if4.rdata, 0);
        rst = 1'b0;
        if4.req = 1'b0;
        @(negedge clk);
        check("ab_rel_ready", if4.ready, 1);
        check("ab_rel_done", if4.done, 0);
        check("ab_rel_op", if4.op, 0);
        check("ab_rel_din", if4.data_input, 0);

        // 3-row build: valid read, then out-of-range read clears rdata
        run3(2'd1, 3'b010, 1'b0, 8'h3C);
        run3(2'd3, 3'b000, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of one memory row word.
REQ-002 SHALL have parameter ROWS, default 4, number of memory rows sequenced.
REQ-003 SHALL have parameter ADDR_W, default 2, host address width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  1  host request, sampled only while ready=1.
REQ-007 we  input  1  1 = write, 0 = read; qualified by req.
REQ-008 addr  input  ADDR_W  target row index.
REQ-009 wdata  input  DATA_W  write data; qualified by req.
REQ-010 ready  output  1  controller idle, can accept req.
REQ-011 done  output  1  one-cycle pulse, access complete.
REQ-012 err  output  1  one-cycle pulse with done; addr >= ROWS.
REQ-013 rdata  output  DATA_W  read result, valid when done=1 and the access was a read.
REQ-014 S  output  ROWS  one-hot row select to memory rows.
REQ-015 op  output  1  row operation: 1 = write, 0 = read.
REQ-016 data_input  output  DATA_W  write data bus to all rows.
REQ-017 data_output  input  DATA_W  shared read data bus from rows.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE, encoded per the shared package.
REQ-019 In IDLE ready=1; req=1 SHALL latch addr, we, wdata and move to SETUP; req=0 stays in IDLE.
REQ-020 In SETUP, S SHALL be all-zero while op and data_input are driven from latched values (setup cycle); next state ACCESS.
REQ-021 In ACCESS, S SHALL equal one-hot(latched addr) for exactly one cycle; next state DONE.
REQ-022 For reads, data_output SHALL be captured into rdata on the ACCESS->DONE edge.
REQ-023 In DONE, done=1 and S all-zero for one cycle; next state IDLE.
REQ-024 Latency: req accepted at edge N SHALL give done=1 in cycle N+3; ready low for cycles N+1..N+3.
REQ-025 Throughput: at most one access per 4 cycles; req while ready=0 SHALL be ignored, not queued.
REQ-026 addr >= ROWS SHALL proceed through all states with S held all-zero, err=1 with done, rdata=0.
REQ-027 op and data_input SHALL hold latched values from SETUP through DONE, no glitching while S active.
REQ-028 rdata SHALL retain its last value until the next read's capture; writes do not alter rdata.
REQ-029 S SHALL never have more than one bit set in any cycle.

Reset
REQ-030 rst=1 at any edge, including mid-access, SHALL force IDLE and abort the access with no done pulse.
REQ-031 Reset values: ready=1 after reset released, done=0, err=0, rdata=0, S=0, op=0, data_input=0, latched registers=0.
REQ-032 rst SHALL take priority over req on the same edge.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef, op encoding constants (OP_READ=0, OP_WRITE=1) and default DATA_W/ROWS/ADDR_W.
REQ-034 One sub-module, row_decoder (addr + enable -> one-hot S, range error flag), SHALL be used; all else inline.

Verification
REQ-035 Write addr=2, wdata=0xA5 -> SETUP: S=0000, op=1, data_input=0xA5; ACCESS: S=0100; done at N+3, err=0.
REQ-036 Row model returns 0x3C on row 1; read addr=1 -> S=0010 in ACCESS, done at N+3 with rdata=0x3C.
REQ-037 req held high continuously -> accepts every 4th cycle, done pulses 4 cycles apart, ready toggles accordingly.
REQ-038 rst asserted during ACCESS -> next cycle IDLE, S=0, no done, ready=1 after release.
REQ-039 ROWS=3 build, read addr=3 -> S stays 000 throughout, done=1, err=1, rdata=0.
REQ-040 Write 0xFF then read same row -> rdata=0xFF, and rdata unchanged by a subsequent write to another row.
